rtc_bus_scheduler: RTL and testbench

//  Sequences and shares the parallel RTC bus (a_d/cs/rd/wr/AD) among pending commands: init, stop ring,

---
 rtl/rtc_bus_pkg.sv | 101 ++++++++++
 rtl/rtc_bus_cycle.sv | 128 ++++++++++++
 rtl/rtc_bus_scheduler.sv | 153 +++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus scheduler: command encoding, state constants,
// write-word indices and the per-command step table.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        CMD_INIC  = 3'd0,
        CMD_STOP  = 3'd1,
        CMD_HORA  = 3'd2,
        CMD_FECHA = 3'd3,
        CMD_TIMER = 3'd4,
        CMD_LEER  = 3'd5
    } cmd_e;

    typedef struct packed {
        logic [7:0] addr;
        logic       is_read;
        logic [3:0] wr_sel;
        logic [3:0] rd_idx;
        logic       last;
    } step_t;

    // Scheduler states
    localparam logic [1:0] SC_IDLE = 2'd0;
    localparam logic [1:0] SC_RUN  = 2'd1;
    localparam logic [1:0] SC_DONE = 2'd2;

    // Bus cycle states
    localparam logic [2:0] BC_IDLE  = 3'd0;
    localparam logic [2:0] BC_ADDR  = 3'd1;
    localparam logic [2:0] BC_REC_A = 3'd2;
    localparam logic [2:0] BC_DATA  = 3'd3;
    localparam logic [2:0] BC_REC_D = 3'd4;

    // Index of the word the external mux must present on wr_data
    localparam logic [3:0] WS_CTRL0 = 4'd0;
    localparam logic [3:0] WS_CTRL1 = 4'd1;
    localparam logic [3:0] WS_CMD   = 4'd2;
    localparam logic [3:0] WS_SEG   = 4'd3;
    localparam logic [3:0] WS_DIA   = 4'd6;
    localparam logic [3:0] WS_TSEG  = 4'd9;
    localparam logic [3:0] WS_XFER  = 4'd12;

    // Lowest pending bit wins: inic > stop > hora > fecha > timer > leer
    function automatic cmd_e pick_cmd(input logic [5:0] pend);
        pick_cmd = CMD_LEER;
        for (int i = 5; i >= 0; i--) begin
            if (pend[i]) pick_cmd = cmd_e'(3'(i));
        end
    endfunction

    function automatic logic [5:0] cmd_mask(input cmd_e cmd);
        return 6'b000001 << cmd;
    endfunction

    function automatic step_t step_lookup(input cmd_e cmd, input logic [3:0] step);
        step_t s;
        s = '0;
        case (cmd)
            CMD_INIC: begin
                s.addr   = (step == 4'd0) ? 8'h02 : 8'h10;
                s.wr_sel = (step == 4'd0) ? WS_CTRL0 : WS_CTRL1;
                s.last   = (step == 4'd1);
            end
            CMD_STOP: begin
                s.addr   = 8'hF1;
                s.wr_sel = WS_CMD;
                s.last   = 1'b1;
            end
            CMD_HORA: begin
                s.addr   = 8'h21 + {4'h0, step};
                s.wr_sel = WS_SEG + step;
                s.last   = (step == 4'd2);
            end
            CMD_FECHA: begin
                s.addr   = 8'h24 + {4'h0, step};
                s.wr_sel = WS_DIA + step;
                s.last   = (step == 4'd2);
            end
            CMD_TIMER: begin
                s.addr   = 8'h41 + {4'h0, step};
                s.wr_sel = WS_TSEG + step;
                s.last   = (step == 4'd2);
            end
            CMD_LEER: begin
                // Step 0 latches the clock into the readable registers, then 9 reads follow
                if (step == 4'd0) begin
                    s.addr   = 8'hF0;
                    s.wr_sel = WS_XFER;
                end else begin
                    s.is_read = 1'b1;
                    s.rd_idx  = step - 4'd1;
                    s.addr    = (step <= 4'd6) ? 8'h20 + {4'h0, step} : 8'h3A + {4'h0, step};
                end
                s.last = (step == 4'd9);
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One RTC bus cycle: address phase, recovery, data phase (write or read), recovery.
// All strobes are registered from the next state so they never glitch.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSE = 4,
    parameter int T_REC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic       is_read,
    input  logic [7:0] wr_data,
    input  logic [7:0] bus_din,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       bus_oe,
    output logic [7:0] bus_dout,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data
);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic       is_read_q, is_read_d;
    logic       a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       pulse_end, rec_end, launch;

    assign pulse_end = (cnt_q == 8'(T_PULSE - 1));
    assign rec_end   = (cnt_q == 8'(T_REC - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        done      = 1'b0;
        launch    = 1'b0;
        case (state_q)
            BC_IDLE: begin
                cnt_d  = 8'd0;
                launch = start;
            end
            BC_ADDR:  if (pulse_end) begin state_d = BC_REC_A; cnt_d = 8'd0; end
            BC_REC_A: if (rec_end)   begin state_d = BC_DATA;  cnt_d = 8'd0; end
            BC_DATA:  if (pulse_end) begin state_d = BC_REC_D; cnt_d = 8'd0; end
            BC_REC_D: begin
                if (rec_end) begin
                    done    = 1'b1;
                    state_d = BC_IDLE;
                    cnt_d   = 8'd0;
                    launch  = start;
                end
            end
            default: state_d = BC_IDLE;
        endcase
        // Back-to-back cycles chain straight from REC_D into ADDR with no idle gap
        if (launch) begin
            state_d   = BC_ADDR;
            cnt_d     = 8'd0;
            addr_d    = addr;
            is_read_d = is_read;
        end

        a_d_d = (state_d != BC_ADDR);
        cs_d  = !(state_d == BC_ADDR || state_d == BC_DATA);
        wr_d  = !(state_d == BC_ADDR || (state_d == BC_DATA && !is_read_d));
        rd_d  = !(state_d == BC_DATA && is_read_d);
        oe_d  = (state_d == BC_ADDR) || (state_d == BC_REC_A) || (state_d == BC_DATA && !is_read_d);

        dout_d = dout_q;
        if (state_d == BC_ADDR)                      dout_d = addr_d;
        else if (state_d == BC_DATA && !is_read_d)   dout_d = wr_data;

        rd_valid_d = (state_q == BC_DATA) && is_read_q && pulse_end;
        rd_data_d  = rd_valid_d ? bus_din : rd_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BC_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 8'd0;
            is_read_q  <= 1'b0;
            a_d_q      <= 1'b1;
            cs_q       <= 1'b1;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= 8'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            a_d_q      <= a_d_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign a_d      = a_d_q;
    assign cs       = cs_q;
    assign rd       = rd_q;
    assign wr       = wr_q;
    assign bus_oe   = oe_q;
    assign bus_dout = dout_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Grant-and-sequence engine for the parallel RTC bus: latches command requests,
// arbitrates by fixed priority and walks each command's step table through rtc_bus_cycle.
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSE = 4,
    parameter int T_REC   = 2,
    parameter int REFRESH = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_inic,
    input  logic       req_stop,
    input  logic       req_hora,
    input  logic       req_fecha,
    input  logic       req_timer,
    input  logic       req_leer,
    input  logic [7:0] wr_data,
    input  logic [7:0] bus_din,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       bus_oe,
    output logic [7:0] bus_dout,
    output logic [3:0] wr_sel,
    output logic       rd_valid,
    output logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       ready
);

    localparam logic        REFRESH_EN   = (REFRESH > 0);
    localparam logic [31:0] REFRESH_LAST = REFRESH_EN ? 32'(REFRESH - 1) : 32'd0;

    logic [1:0]  state_q, state_d;
    logic [5:0]  pend_q, pend_d, pend_set;
    cmd_e        cmd_q, cmd_d;
    logic [3:0]  step_q, step_d;
    logic        last_q, last_d;
    logic [31:0] refresh_q, refresh_d;
    logic        busy_q, busy_d, ready_q, ready_d;
    logic [3:0]  wr_sel_q, wr_sel_d, rd_idx_q, rd_idx_d;
    logic        refresh_hit, start, cycle_done;
    step_t       nxt;

    always_comb begin
        refresh_hit = REFRESH_EN && (refresh_q == REFRESH_LAST);
        refresh_d   = (refresh_hit || !REFRESH_EN) ? 32'd0 : refresh_q + 32'd1;
        pend_set    = {req_leer | refresh_hit, req_timer, req_fecha, req_hora, req_stop, req_inic};
        pend_d      = pend_q | pend_set;

        state_d  = state_q;
        cmd_d    = cmd_q;
        step_d   = step_q;
        last_d   = last_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        wr_sel_d = wr_sel_q;
        rd_idx_d = rd_idx_q;
        start    = 1'b0;

        case (state_q)
            SC_IDLE: begin
                if (|pend_q) begin
                    cmd_d   = pick_cmd(pend_q);
                    step_d  = 4'd0;
                    start   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SC_RUN;
                    // New pulses are OR-ed back in after the clear, so a re-request survives the grant
                    pend_d  = (pend_q & ~cmd_mask(cmd_d)) | pend_set;
                end
            end
            SC_RUN: begin
                if (cycle_done) begin
                    if (last_q) begin
                        state_d = SC_DONE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        step_d = step_q + 4'd1;
                        start  = 1'b1;
                    end
                end
            end
            SC_DONE: state_d = SC_IDLE;
            default: state_d = SC_IDLE;
        endcase

        nxt = step_lookup(cmd_d, step_d);
        if (start) begin
            last_d   = nxt.last;
            wr_sel_d = nxt.wr_sel;
            rd_idx_d = nxt.rd_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SC_IDLE;
            pend_q    <= 6'd0;
            cmd_q     <= CMD_INIC;
            step_q    <= 4'd0;
            last_q    <= 1'b0;
            refresh_q <= 32'd0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            wr_sel_q  <= 4'd0;
            rd_idx_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cmd_q     <= cmd_d;
            step_q    <= step_d;
            last_q    <= last_d;
            refresh_q <= refresh_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            wr_sel_q  <= wr_sel_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    rtc_bus_cycle #(
        .T_PULSE (T_PULSE),
        .T_REC   (T_REC)
    ) u_cycle (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (nxt.addr),
        .is_read  (nxt.is_read),
        .wr_data  (wr_data),
        .bus_din  (bus_din),
        .a_d      (a_d),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .bus_oe   (bus_oe),
        .bus_dout (bus_dout),
        .done     (cycle_done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    assign wr_sel = wr_sel_q;
    assign rd_idx = rd_idx_q;
    assign busy   = busy_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: expected bus transactions and read results are
// queued when requests are driven and compared as the bus monitor sees them complete.
module tb_rtc_bus_scheduler;

    typedef struct { logic [7:0] addr; logic rd; logic [7:0] data; } txn_t;
    typedef struct { logic [3:0] idx; logic [7:0] data; } rdx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset_r;
    logic       req_inic, req_stop, req_hora, req_fecha, req_timer, req_leer;
    logic [7:0] wr_data, bus_din;
    logic       a_d, cs, rd, wr, bus_oe, rd_valid, busy, ready;
    logic [7:0] bus_dout, rd_data;
    logic [3:0] wr_sel, rd_idx;

    logic       r_a_d, r_cs, r_rd, r_wr, r_bus_oe, r_rd_valid, r_busy, r_ready;
    logic [7:0] r_bus_dout, r_rd_data;
    logic [3:0] r_wr_sel, r_rd_idx;

    rtc_bus_scheduler #(.T_PULSE(4), .T_REC(2), .REFRESH(0)) dut (
        .clk(clk), .reset(reset),
        .req_inic(req_inic), .req_stop(req_stop), .req_hora(req_hora),
        .req_fecha(req_fecha), .req_timer(req_timer), .req_leer(req_leer),
        .wr_data(wr_data), .bus_din(bus_din),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .bus_oe(bus_oe), .bus_dout(bus_dout),
        .wr_sel(wr_sel), .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .ready(ready)
    );

    rtc_bus_scheduler #(.T_PULSE(4), .T_REC(2), .REFRESH(50)) dut_r (
        .clk(clk), .reset(reset_r),
        .req_inic(1'b0), .req_stop(1'b0), .req_hora(1'b0),
        .req_fecha(1'b0), .req_timer(1'b0), .req_leer(1'b0),
        .wr_data(8'h00), .bus_din(8'h00),
        .a_d(r_a_d), .cs(r_cs), .rd(r_rd), .wr(r_wr), .bus_oe(r_bus_oe), .bus_dout(r_bus_dout),
        .wr_sel(r_wr_sel), .rd_valid(r_rd_valid), .rd_idx(r_rd_idx), .rd_data(r_rd_data),
        .busy(r_busy), .ready(r_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Words the external mux presents for each wr_sel index
    logic [7:0] wtab [16];
    assign wr_data = wtab[wr_sel];

    // RTC register model: read registers return 0x10 + read index
    logic [7:0] seen_addr = 8'h00;
    function automatic logic [7:0] rtc_reg(input logic [7:0] a);
        if (a >= 8'h21 && a <= 8'h26) return 8'h10 + (a - 8'h21);
        if (a >= 8'h41 && a <= 8'h43) return 8'h16 + (a - 8'h41);
        return 8'hEE;
    endfunction
    assign bus_din = rtc_reg(seen_addr);

    txn_t exp_q[$];
    rdx_t exp_rd_q[$];

    task automatic push_w(input logic [7:0] a, input int sel);
        txn_t t;
        t.addr = a; t.rd = 1'b0; t.data = wtab[sel];
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [7:0] a, input int idx);
        txn_t t;
        rdx_t r;
        t.addr = a; t.rd = 1'b1; t.data = 8'h00;
        r.idx = 4'(idx); r.data = 8'h10 + 8'(idx);
        exp_q.push_back(t);
        exp_rd_q.push_back(r);
    endtask

    task automatic exp_inic();  push_w(8'h02, 0); push_w(8'h10, 1); endtask
    task automatic exp_stop();  push_w(8'hF1, 2); endtask
    task automatic exp_hora();  push_w(8'h21, 3); push_w(8'h22, 4); push_w(8'h23, 5); endtask
    task automatic exp_fecha(); push_w(8'h24, 6); push_w(8'h25, 7); push_w(8'h26, 8); endtask
    task automatic exp_timer(); push_w(8'h41, 9); push_w(8'h42, 10); push_w(8'h43, 11); endtask
    task automatic exp_leer();
        push_w(8'hF0, 12);
        push_r(8'h21, 0); push_r(8'h22, 1); push_r(8'h23, 2);
        push_r(8'h24, 3); push_r(8'h25, 4); push_r(8'h26, 5);
        push_r(8'h41, 6); push_r(8'h42, 7); push_r(8'h43, 8);
    endtask

    // Bus monitor and scoreboard
    logic       mon_en = 1'b1;
    logic       in_data = 1'b0;
    logic       mon_rd = 1'b0;
    logic [7:0] mon_addr = 8'h00, mon_data = 8'h00;
    logic       prev_cs = 1'b1, prev_a_d = 1'b1;
    txn_t       mon_t;
    rdx_t       mon_r;
    int         ready_cnt = 0, busy_cyc = 0, rd_cnt = 0;
    int         r_ready_cnt = 0, r_rd_cnt = 0;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            in_data = 1'b0;
        end else begin
            if (!cs && !prev_cs) check("a_d_stable_while_cs", 32'(a_d), 32'(prev_a_d));
            if (!cs && !a_d) begin
                mon_addr  = bus_dout;
                seen_addr = bus_dout;
                check("oe_in_addr", 32'(bus_oe), 32'd1);
            end
            if (!cs && a_d) begin
                in_data  = 1'b1;
                mon_rd   = !rd;
                mon_data = bus_dout;
                check("oe_in_data", 32'(bus_oe), 32'(rd));
            end
            if (cs && in_data) begin
                in_data = 1'b0;
                check("txn_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_t = exp_q.pop_front();
                    check("txn_addr", 32'(mon_addr), 32'(mon_t.addr));
                    check("txn_dir", 32'(mon_rd), 32'(mon_t.rd));
                    if (!mon_t.rd) check("txn_wdata", 32'(mon_data), 32'(mon_t.data));
                end
            end
        end
        prev_cs  = cs;
        prev_a_d = a_d;
        if (busy) busy_cyc++;
        if (ready) begin
            ready_cnt++;
            check("busy_low_at_ready", 32'(busy), 32'd0);
        end
        if (rd_valid) begin
            rd_cnt++;
            check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) begin
                mon_r = exp_rd_q.pop_front();
                check("rd_idx", 32'(rd_idx), 32'(mon_r.idx));
                check("rd_data", 32'(rd_data), 32'(mon_r.data));
            end
        end
        if (r_ready) r_ready_cnt++;
        if (r_rd_valid) r_rd_cnt++;
    end

    task automatic pulse(input logic [5:0] v);
        {req_leer, req_timer, req_fecha, req_hora, req_stop, req_inic} = v;
        @(negedge clk);
        {req_leer, req_timer, req_fecha, req_hora, req_stop, req_inic} = 6'd0;
    endtask

    task automatic wait_ready(input string tag, input int target, input int budget);
        int n = 0;
        while (ready_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(ready_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        bit found;

        wtab[0]  = 8'hA0; wtab[1]  = 8'hA1; wtab[2]  = 8'h5A; wtab[3]  = 8'h45;
        wtab[4]  = 8'h30; wtab[5]  = 8'h12; wtab[6]  = 8'h15; wtab[7]  = 8'h06;
        wtab[8]  = 8'h24; wtab[9]  = 8'h09; wtab[10] = 8'h08; wtab[11] = 8'h07;
        wtab[12] = 8'hC3; wtab[13] = 8'h00; wtab[14] = 8'h00; wtab[15] = 8'h00;

        reset = 1'b1; reset_r = 1'b1;
        {req_leer, req_timer, req_fecha, req_hora, req_stop, req_inic} = 6'd0;
        repeat (3) @(negedge clk);

        check("rst_strobes", 32'({a_d, cs, rd, wr}), 32'hF);
        check("rst_bus_oe", 32'(bus_oe), 32'd0);
        check("rst_bus_dout", 32'(bus_dout), 32'd0);
        check("rst_wr_sel", 32'(wr_sel), 32'd0);
        check("rst_rd_flags", 32'({rd_valid, rd_idx, rd_data}), 32'd0);
        check("rst_busy_ready", 32'({busy, ready}), 32'd0);

        reset = 1'b0;
        repeat (2) @(negedge clk);

        // hora: three writes, ready 36+1 clocks after the request
        exp_hora();
        busy_cyc = 0;
        pulse(6'b000100);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!ready && cyc < 100);
        check("hora_latency", 32'(cyc), 32'd37);
        @(negedge clk);
        check("hora_busy_cycles", 32'(busy_cyc), 32'd36);
        check("hora_ready_cnt", 32'(ready_cnt), 32'd1);
        check("hora_drained", 32'(exp_q.size()), 32'd0);

        // read-all: transfer write then nine reads
        exp_leer();
        busy_cyc = 0;
        pulse(6'b100000);
        wait_ready("leer_ready", 2, 200);
        check("leer_busy_cycles", 32'(busy_cyc), 32'd120);
        check("leer_rd_count", 32'(rd_cnt), 32'd9);
        check("leer_drained", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);

        // leer and inic in the same cycle: inic first
        base = ready_cnt;
        exp_inic();
        exp_leer();
        pulse(6'b100001);
        wait_ready("inic_leer_ready", base + 2, 400);
        check("inic_leer_drained", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);

        // stop and timer in the same cycle: stop first
        base = ready_cnt;
        exp_stop();
        exp_timer();
        pulse(6'b010010);
        wait_ready("stop_timer_ready", base + 2, 200);
        check("stop_timer_drained", 32'(exp_q.size()), 32'd0);

        // fecha pulsed three times while hora runs: fecha runs once
        base = ready_cnt;
        exp_hora();
        exp_fecha();
        pulse(6'b000100);
        repeat (5) @(negedge clk);
        pulse(6'b001000);
        repeat (10) @(negedge clk);
        pulse(6'b001000);
        repeat (10) @(negedge clk);
        pulse(6'b001000);
        wait_ready("merge_ready", base + 2, 300);
        repeat (30) @(negedge clk);
        check("merge_ready_total", 32'(ready_cnt), 32'(base + 2));
        check("merge_idle", 32'(busy), 32'd0);
        check("merge_drained", 32'(exp_q.size()), 32'd0);

        // reset during the data phase of a write aborts at once, without ready
        base = ready_cnt;
        mon_en = 1'b0;
        pulse(6'b000100);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!cs && a_d && !wr) found = 1'b1;
        end
        check("abort_reached_data", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_strobes", 32'({a_d, cs, rd, wr}), 32'hF);
        check("abort_bus_oe", 32'(bus_oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_ready", 32'(ready_cnt), 32'(base));
        check("abort_stays_idle", 32'(busy), 32'd0);
        exp_q.delete();
        exp_rd_q.delete();
        mon_en = 1'b1;

        // recovery after abort
        base = ready_cnt;
        exp_stop();
        pulse(6'b000010);
        wait_ready("recover_ready", base + 1, 100);
        check("recover_drained", 32'(exp_q.size()), 32'd0);

        // periodic refresh on the second instance
        reset_r = 1'b0;
        cyc = 0;
        while (!r_busy && cyc < 200) begin @(negedge clk); cyc++; end
        check("refresh_first_start", 32'(cyc >= 50 && cyc <= 52), 32'd1);
        cyc = 0;
        while (r_ready_cnt < 1 && cyc < 200) begin @(negedge clk); cyc++; end
        check("refresh_ready", 32'(r_ready_cnt), 32'd1);
        check("refresh_rd_count", 32'(r_rd_cnt), 32'd9);
        cyc = 0;
        while (!r_busy && cyc < 10) begin @(negedge clk); cyc++; end
        check("refresh_deferred_start", 32'(r_busy && cyc <= 3), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
